retire_trace_buf: RTL and testbench

RETIRE_TRACE_BUF -- requirements
Module: retire_trace_buf

---
 rtl/retire_trace_buf.sv | 145 ++++++++++++++
 tb/tb_retire_trace_buf.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buf.sv
// Retirement trace buffer: turns retire events into typed records in a show-ahead FIFO,
// with cycle/instruction/drop statistics. Optional macro TRACE_FILTER_EN drops kind-0 records.
module retire_trace_buf #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ev_valid,
    input  logic [ADDR_W-1:0] ev_pc,
    input  logic [DATA_W-1:0] ev_inst,
    input  logic              ev_regwrite,
    input  logic [3:0]        ev_wreg,
    input  logic [DATA_W-1:0] ev_wdata,
    input  logic              ev_memread,
    input  logic              ev_memwrite,
    input  logic [ADDR_W-1:0] ev_maddr,
    input  logic [DATA_W-1:0] ev_mdata,
    input  logic              ev_halt,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [1:0]        rd_kind,
    output logic              rd_load,
    output logic [CNT_W-1:0]  rd_inum,
    output logic [ADDR_W-1:0] rd_pc,
    output logic [3:0]        rd_reg,
    output logic [DATA_W-1:0] rd_value,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              halted,
    output logic              timeout,
    output logic              overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

    typedef struct packed {
        logic [1:0]        kind;
        logic              load;
        logic [CNT_W-1:0]  inum;
        logic [ADDR_W-1:0] pc;
        logic [3:0]        rnum;
        logic [DATA_W-1:0] value;
        logic [ADDR_W-1:0] addr;
    } rec_t;

    rec_t              r_mem [DEPTH];
    logic [PTR_W:0]    r_wptr, r_rptr;
    logic [CNT_W-1:0]  r_cycle_cnt, r_inst_cnt, r_drop_cnt;
    logic              r_halted, r_timeout, r_overflow;

    rec_t              w_rec, w_head;
    logic              w_accept, w_push_req, w_push, w_pop, w_drop;
    logic              w_empty, w_full;

    // ev_inst is part of the retire bundle but no record kind carries it
    logic              w_unused_inst;
    assign w_unused_inst = ^ev_inst;

    assign w_accept = ev_valid & ~r_halted & ~r_timeout;

    always_comb begin
        w_rec      = '0;
        w_rec.inum = r_inst_cnt;
        w_rec.pc   = ev_pc;
        if (ev_halt) begin
            w_rec.kind = 2'd3;
        end else if (ev_regwrite) begin
            w_rec.kind  = 2'd1;
            w_rec.value = ev_wdata;
            w_rec.rnum  = ev_wreg;
            w_rec.load  = ev_memread;
            w_rec.addr  = ev_maddr;
        end else if (ev_memwrite) begin
            w_rec.kind  = 2'd2;
            w_rec.value = ev_mdata;
            w_rec.addr  = ev_maddr;
        end
    end

`ifdef TRACE_FILTER_EN
    assign w_push_req = w_accept & (w_rec.kind != 2'd0);
`else
    assign w_push_req = w_accept;
`endif

    // Extra MSB on the pointers separates full from empty when the indices match
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_pop   = ~w_empty & rd_ready;
    assign w_push  = w_push_req & (~w_full | w_pop);
    assign w_drop  = w_push_req & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= w_rec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
            r_drop_cnt  <= '0;
            r_halted    <= 1'b0;
            r_timeout   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            // Hold at the bound so the frozen count equals CYCLE_LIMIT once timeout sets
            if (~r_halted && ~r_timeout && r_cycle_cnt != LIMIT)
                r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (r_cycle_cnt == LIMIT) r_timeout <= 1'b1;
            if (w_accept) r_inst_cnt <= r_inst_cnt + 1'b1;
            if (w_accept && ev_halt) r_halted <= 1'b1;
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head    = r_mem[r_rptr[PTR_W-1:0]];
    assign rd_valid  = ~w_empty;
    assign rd_kind   = w_head.kind;
    assign rd_load   = w_head.load;
    assign rd_inum   = w_head.inum;
    assign rd_pc     = w_head.pc;
    assign rd_reg    = w_head.rnum;
    assign rd_value  = w_head.value;
    assign rd_addr   = w_head.addr;
    assign cycle_cnt = r_cycle_cnt;
    assign inst_cnt  = r_inst_cnt;
    assign drop_cnt  = r_drop_cnt;
    assign halted    = r_halted;
    assign timeout   = r_timeout;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_retire_trace_buf.sv
// Directed bench for retire_trace_buf at DEPTH=4, CYCLE_LIMIT=20: vector table plus
// hand-written sequences for overflow, full push/pop, timeout, reset and filtering.
module tb_retire_trace_buf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ev_valid, ev_regwrite, ev_memread, ev_memwrite, ev_halt;
    logic [15:0] ev_pc, ev_inst, ev_wdata, ev_maddr, ev_mdata;
    logic [3:0]  ev_wreg;
    logic        rd_valid, rd_ready, rd_load;
    logic [1:0]  rd_kind;
    logic [31:0] rd_inum, cycle_cnt, inst_cnt, drop_cnt;
    logic [15:0] rd_pc, rd_value, rd_addr;
    logic [3:0]  rd_reg;
    logic        halted, timeout, overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    retire_trace_buf #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .CNT_W(32), .CYCLE_LIMIT(20)) dut (
        .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_pc(ev_pc), .ev_inst(ev_inst),
        .ev_regwrite(ev_regwrite), .ev_wreg(ev_wreg), .ev_wdata(ev_wdata),
        .ev_memread(ev_memread), .ev_memwrite(ev_memwrite), .ev_maddr(ev_maddr),
        .ev_mdata(ev_mdata), .ev_halt(ev_halt), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_kind(rd_kind), .rd_load(rd_load), .rd_inum(rd_inum), .rd_pc(rd_pc),
        .rd_reg(rd_reg), .rd_value(rd_value), .rd_addr(rd_addr), .cycle_cnt(cycle_cnt),
        .inst_cnt(inst_cnt), .drop_cnt(drop_cnt), .halted(halted), .timeout(timeout),
        .overflow(overflow)
    );

    typedef struct {
        logic        v, h, rw, mr, mw, rdy;
        logic [3:0]  wr;
        logic [15:0] wd, pc, ma, md;
        logic        e_vld;
        logic [1:0]  e_kind;
        logic [31:0] e_inum;
        logic [15:0] e_pc, e_val, e_addr;
        logic [3:0]  e_reg;
        logic        e_load, e_halt;
        logic [31:0] e_inst, e_cyc;
    } vec_t;

    vec_t tv [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic v, input logic h, input logic rw, input logic mr,
                      input logic mw, input logic [3:0] wr, input logic [15:0] wd,
                      input logic [15:0] pc, input logic [15:0] ma, input logic [15:0] md);
        ev_valid = v; ev_halt = h; ev_regwrite = rw; ev_memread = mr; ev_memwrite = mw;
        ev_wreg = wr; ev_wdata = wd; ev_pc = pc; ev_maddr = ma; ev_mdata = md;
        ev_inst = pc ^ 16'hA5A5;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; rd_ready = 1'b0;
        ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //             v h rw mr mw rdy wr wd       pc       ma       md        vld k inum pc       val      addr     reg ld hlt inst cyc
        tv[0] = '{1, 0, 1, 0, 0, 1, 3, 16'h1234, 16'h0002, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0};
        tv[1] = '{1, 0, 0, 0, 1, 1, 0, 16'h0000, 16'h0004, 16'h0010, 16'hBEEF, 1, 1, 0, 16'h0002, 16'h1234, 16'h0000, 3, 0, 0, 1, 1};
        tv[2] = '{1, 1, 0, 0, 0, 1, 0, 16'h0000, 16'h0006, 16'h0000, 16'h0000, 1, 2, 1, 16'h0004, 16'hBEEF, 16'h0010, 0, 0, 0, 2, 2};
        tv[3] = '{0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 3, 2, 16'h0006, 16'h0000, 16'h0000, 0, 0, 1, 3, 3};
        tv[4] = '{1, 0, 1, 0, 0, 1, 5, 16'h7777, 16'h0008, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 3, 3};
        tv[5] = '{0, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 3, 3};

        // Reset state, then idle counting
        do_reset();
        chk("rst_cycle", cycle_cnt, 0);
        chk("rst_inst", inst_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_overflow", overflow, 0);
        repeat (5) step();
        chk("idle_cycle5", cycle_cnt, 5);
        chk("idle_inst", inst_cnt, 0);
        chk("idle_valid", rd_valid, 0);

        // Reg write, store, halt streamed out with rd_ready=1
        do_reset();
        for (int i = 0; i < 6; i++) begin
            ev(tv[i].v, tv[i].h, tv[i].rw, tv[i].mr, tv[i].mw, tv[i].wr, tv[i].wd,
               tv[i].pc, tv[i].ma, tv[i].md);
            rd_ready = tv[i].rdy;
            #1;
            chk($sformatf("v%0d_valid", i), rd_valid, tv[i].e_vld);
            chk($sformatf("v%0d_halted", i), halted, tv[i].e_halt);
            chk($sformatf("v%0d_inst", i), inst_cnt, tv[i].e_inst);
            chk($sformatf("v%0d_cycle", i), cycle_cnt, tv[i].e_cyc);
            if (tv[i].e_vld) begin
                chk($sformatf("v%0d_kind", i), rd_kind, tv[i].e_kind);
                chk($sformatf("v%0d_inum", i), rd_inum, tv[i].e_inum);
                chk($sformatf("v%0d_pc", i), rd_pc, tv[i].e_pc);
                chk($sformatf("v%0d_value", i), rd_value, tv[i].e_val);
                chk($sformatf("v%0d_addr", i), rd_addr, tv[i].e_addr);
                chk($sformatf("v%0d_reg", i), rd_reg, tv[i].e_reg);
                chk($sformatf("v%0d_load", i), rd_load, tv[i].e_load);
            end
            step();
        end
        ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Overflow: six events into a four-deep FIFO with no readout
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ev(1, 0, 1, 1, 0, 4'(i), 16'(16'h0100 + i), 16'(i * 2), 16'h0040, 0);
            step();
        end
        ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_flag", overflow, 1);
        chk("ovf_inst", inst_cnt, 6);
        chk("ovf_load", rd_load, 1);
        chk("ovf_addr", rd_addr, 16'h0040);
        step();
        chk("ovf_stall_inum", rd_inum, 0);
        chk("ovf_stall_value", rd_value, 16'h0100);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_rd%0d_valid", i), rd_valid, 1);
            chk($sformatf("ovf_rd%0d_inum", i), rd_inum, i);
            chk($sformatf("ovf_rd%0d_value", i), rd_value, 16'(16'h0100 + i));
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        chk("ovf_empty", rd_valid, 0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ev(1, 0, 1, 0, 0, 4'd1, 16'(i), 0, 0, 0);
            step();
        end
        ev(1, 0, 1, 0, 0, 4'd2, 16'h0055, 0, 0, 0);
        rd_ready = 1'b1;
        step();
        ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rd_ready = 1'b0;
        #1;
        chk("pp_drop", drop_cnt, 0);
        chk("pp_overflow", overflow, 0);
        chk("pp_inst", inst_cnt, 5);
        chk("pp_head", rd_inum, 1);
        rd_ready = 1'b1;
        n = 0;
        while (rd_valid && n < 10) begin
            chk($sformatf("pp_rd%0d_inum", n), rd_inum, n + 1);
            n++;
            step();
        end
        chk("pp_occupancy", n, 4);
        rd_ready = 1'b0;

        // Reset while buffering discards records and ignores the event under reset
        do_reset();
        ev(1, 0, 0, 0, 1, 0, 0, 16'h0010, 16'h0020, 16'h0030);
        step();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_inst", inst_cnt, 0);
        chk("mid_rst_cycle", cycle_cnt, 0);

        // Watchdog: counter stops at the bound, later events ignored
        do_reset();
        repeat (20) step();
        chk("to_cycle_at_limit", cycle_cnt, 20);
        chk("to_not_yet", timeout, 0);
        step();
        chk("to_set", timeout, 1);
        repeat (4) step();
        chk("to_cycle_frozen", cycle_cnt, 20);
        ev(1, 0, 1, 0, 0, 1, 16'h9999, 0, 0, 0);
        step();
        ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_inst", inst_cnt, 0);
        chk("to_valid", rd_valid, 0);

        // Kind-0, kind-1, kind-0 sequence
        do_reset();
        rd_ready = 1'b0;
        ev(1, 0, 0, 1, 0, 0, 0, 16'h0100, 0, 0); step();
        ev(1, 0, 1, 0, 0, 7, 16'h00AA, 16'h0102, 0, 0); step();
        ev(1, 0, 0, 0, 0, 0, 0, 16'h0104, 0, 0); step();
        ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flt_inst", inst_cnt, 3);
`ifdef TRACE_FILTER_EN
        chk("flt_inum", rd_inum, 1);
        chk("flt_kind", rd_kind, 1);
        chk("flt_value", rd_value, 16'h00AA);
        rd_ready = 1'b1;
        step();
        chk("flt_only_one", rd_valid, 0);
`else
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("nf_rd%0d_valid", i), rd_valid, 1);
            chk($sformatf("nf_rd%0d_inum", i), rd_inum, i);
            chk($sformatf("nf_rd%0d_kind", i), rd_kind, (i == 1) ? 2'd1 : 2'd0);
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        chk("nf_empty", rd_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
